// File: rtl/overcooked_pkg.sv
// Shared game definitions: game-state codes, slot count and the score/time types,
// plus the score clamp used when applying signed score deltas.
package overcooked_pkg;

  localparam logic [2:0] WELCOME = 3'd0;
  localparam logic [2:0] START   = 3'd1;
  localparam logic [2:0] PLAY    = 3'd2;
  localparam logic [2:0] PAUSE   = 3'd3;
  localparam logic [2:0] FINISH  = 3'd4;

  localparam int NUM_ORDER_SLOTS = 4;

  typedef logic [4:0] order_time_t;
  typedef logic [9:0] points_t;

  function automatic points_t clampPoints(input logic signed [11:0] value);
    if (value < 12'sd0) begin
      return '0;
    end else if (value > 12'sd1023) begin
      return 10'd1023;
    end else begin
      return value[9:0];
    end
  endfunction

endpackage

// File: rtl/order_scheduler_second_tick.sv
// Game-second strobe: counts clock cycles while enabled and pulses tick for one
// cycle every CLK_HZ enabled cycles; the phase is held while enable is low.
module second_tick #(
  parameter int CLK_HZ = 65_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [CW-1:0] r_count;

  assign tick = enable && (r_count == CW'(CLK_HZ - 1));

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (tick) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/order_scheduler.sv
// Four-slot order manager: spawns orders on a fixed cadence, counts them down each
// game second, serves the most urgent order on request and keeps the saturating score.
module order_scheduler
  import overcooked_pkg::*;
#(
  parameter int CLK_HZ         = 65_000_000,
  parameter int ORDER_LIFETIME = 30,
  parameter int SPAWN_INTERVAL = 10,
  parameter int SERVE_POINTS   = 20,
  parameter int EXPIRE_PENALTY = 10
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [2:0]                             game_state,
  input  logic                                   serve_valid,
  output logic                                   serve_ack,
  output logic                                   serve_nack,
  output logic [NUM_ORDER_SLOTS-1:0]             orders,
  output logic [NUM_ORDER_SLOTS-1:0][4:0]        order_times,
  output logic [9:0]                             point_total
);

  localparam int SW = $clog2(NUM_ORDER_SLOTS);

  order_time_t [NUM_ORDER_SLOTS-1:0] r_times;
  order_time_t [NUM_ORDER_SLOTS-1:0] w_nextTimes;
  logic [NUM_ORDER_SLOTS-1:0]        r_orders;
  logic [NUM_ORDER_SLOTS-1:0]        w_nextOrders;
  points_t                           r_points;
  points_t                           w_nextPoints;
  logic                              r_ack;
  logic                              r_nack;
  logic [7:0]                        r_spawnCnt;
  logic [7:0]                        w_spawnCntInc;
  logic                              w_tick;
  logic                              w_play;
  logic                              w_clear;
  logic                              w_found;
  logic                              w_doServe;
  logic                              w_spawnNow;
  logic                              w_spawnDone;
  logic [SW-1:0]                     w_target;
  order_time_t                       w_best;
  logic [2:0]                        w_expireCnt;
  logic [11:0]                       w_award;
  logic [11:0]                       w_penalty;
  logic signed [11:0]                w_delta;
  logic signed [11:0]                w_sum;

  assign w_play  = (game_state == PLAY);
  assign w_clear = (game_state == WELCOME) || (game_state == START);

  second_tick #(.CLK_HZ(CLK_HZ)) u_secondTick (
    .clock  (clock),
    .reset  (reset),
    .enable (w_play),
    .clear  (w_clear),
    .tick   (w_tick)
  );

  // Serve target: smallest remaining time, strict compare keeps the lowest index on ties.
  always_comb begin
    w_found  = 1'b0;
    w_target = '0;
    w_best   = '0;
    for (int i = 0; i < NUM_ORDER_SLOTS; i++) begin
      if (r_times[i] != '0 && (!w_found || r_times[i] < w_best)) begin
        w_found  = 1'b1;
        w_target = SW'(i);
        w_best   = r_times[i];
      end
    end
  end

  assign w_doServe = serve_valid && w_play && w_found;

  // Spawns only look at slots empty at the start of the cycle, so freed slots wait a tick.
  always_comb begin
    w_nextTimes   = r_times;
    w_expireCnt   = '0;
    w_spawnDone   = 1'b0;
    w_spawnCntInc = r_spawnCnt + 8'd1;
    w_spawnNow    = w_tick && (w_spawnCntInc == 8'(SPAWN_INTERVAL));
    for (int i = 0; i < NUM_ORDER_SLOTS; i++) begin
      if (w_doServe && w_target == SW'(i)) begin
        w_nextTimes[i] = '0;
      end else if (w_tick && r_times[i] != '0) begin
        if (r_times[i] == 5'd1) begin
          w_nextTimes[i] = '0;
          w_expireCnt    = w_expireCnt + 3'd1;
        end else begin
          w_nextTimes[i] = r_times[i] - 5'd1;
        end
      end
    end
    for (int i = 0; i < NUM_ORDER_SLOTS; i++) begin
      if (w_spawnNow && !w_spawnDone && r_times[i] == '0) begin
        w_nextTimes[i] = 5'(ORDER_LIFETIME);
        w_spawnDone    = 1'b1;
      end
    end
    for (int i = 0; i < NUM_ORDER_SLOTS; i++) begin
      w_nextOrders[i] = |w_nextTimes[i];
    end
  end

  assign w_award      = w_doServe ? (12'(SERVE_POINTS) + 12'(w_best)) : 12'd0;
  assign w_penalty    = 12'(EXPIRE_PENALTY) * 12'(w_expireCnt);
  assign w_delta      = $signed(w_award - w_penalty);
  assign w_sum        = $signed({2'b00, r_points}) + w_delta;
  assign w_nextPoints = clampPoints(w_sum);

  always_ff @(posedge clock) begin
    if (reset || w_clear) begin
      r_times    <= '0;
      r_orders   <= '0;
      r_points   <= '0;
      r_spawnCnt <= 8'(SPAWN_INTERVAL - 1);
    end else begin
      r_times  <= w_nextTimes;
      r_orders <= w_nextOrders;
      r_points <= w_nextPoints;
      if (w_tick) begin
        r_spawnCnt <= w_spawnNow ? 8'd0 : w_spawnCntInc;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ack  <= 1'b0;
      r_nack <= 1'b0;
    end else begin
      r_ack  <= w_doServe;
      r_nack <= serve_valid && !w_doServe;
    end
  end

  assign serve_ack   = r_ack;
  assign serve_nack  = r_nack;
  assign orders      = r_orders;
  assign order_times = r_times;
  assign point_total = r_points;

endmodule

// File: tb/tb_order_scheduler.sv
// Directed bench for order_scheduler with CLK_HZ=10, ORDER_LIFETIME=3, SPAWN_INTERVAL=2:
// a per-tick table for the free-running fill/expiry pattern, then hand sequences.
module tb_order_scheduler;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [2:0]       game_state = 3'd0;
  logic             serve_valid = 1'b0;
  logic             serve_ack;
  logic             serve_nack;
  logic [3:0]       orders;
  logic [3:0][4:0]  order_times;
  logic [9:0]       point_total;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  orders;
    logic [19:0] times;
    logic [9:0]  points;
  } tickVec_t;

  tickVec_t vecs[10];

  order_scheduler #(
    .CLK_HZ(10), .ORDER_LIFETIME(3), .SPAWN_INTERVAL(2),
    .SERVE_POINTS(20), .EXPIRE_PENALTY(10)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .game_state  (game_state),
    .serve_valid (serve_valid),
    .serve_ack   (serve_ack),
    .serve_nack  (serve_nack),
    .orders      (orders),
    .order_times (order_times),
    .point_total (point_total)
  );

  always #5 clock = ~clock;

  function automatic logic [19:0] packT(input int s0, input int s1, input int s2, input int s3);
    return {5'(s3), 5'(s2), 5'(s1), 5'(s0)};
  endfunction

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d want %0d", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string name, input logic [3:0] expOrders, input logic [19:0] expTimes,
                             input logic [9:0] expPoints, input logic expAck, input logic expNack);
    checkVal({name, ".orders"}, 32'(orders), 32'(expOrders));
    checkVal({name, ".times"}, 32'(order_times), 32'(expTimes));
    checkVal({name, ".points"}, 32'(point_total), 32'(expPoints));
    checkVal({name, ".ack"}, 32'(serve_ack), 32'(expAck));
    checkVal({name, ".nack"}, 32'(serve_nack), 32'(expNack));
  endtask

  task automatic waitForOrder(input string name);
    int waited;
    waited = 0;
    while (orders == 4'b0000 && waited < 25) begin
      applyStimulus(1);
      waited++;
    end
    if (orders == 4'b0000) begin
      total++;
      bad++;
      $display("[TB] FAIL %s: got no spawn within %0d cycles want a spawn", name, waited);
    end
  endtask

  initial begin
    logic [3:0]  prevOrders;
    logic [19:0] prevTimes;
    int          expPoints;

    vecs[0] = '{4'b0001, packT(3, 0, 0, 0), 10'd0};
    vecs[1] = '{4'b0001, packT(2, 0, 0, 0), 10'd0};
    vecs[2] = '{4'b0011, packT(1, 3, 0, 0), 10'd0};
    vecs[3] = '{4'b0010, packT(0, 2, 0, 0), 10'd0};
    vecs[4] = '{4'b0011, packT(3, 1, 0, 0), 10'd0};
    vecs[5] = '{4'b0001, packT(2, 0, 0, 0), 10'd0};
    vecs[6] = '{4'b0011, packT(1, 3, 0, 0), 10'd0};
    vecs[7] = '{4'b0010, packT(0, 2, 0, 0), 10'd0};
    vecs[8] = '{4'b0011, packT(3, 1, 0, 0), 10'd0};
    vecs[9] = '{4'b0001, packT(2, 0, 0, 0), 10'd0};

    applyStimulus(2);
    reset = 1'b0;
    applyStimulus(1);
    checkOutput("reset", 4'b0000, 20'd0, 10'd0, 1'b0, 1'b0);
    game_state = 3'd1;
    applyStimulus(1);
    game_state = 3'd2;

    // Free-running fill with expiries; the tick lands on the 10th cycle of each second.
    prevOrders = 4'b0000;
    prevTimes  = 20'd0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(9);
      checkVal($sformatf("preTick%0d.orders", k + 1), 32'(orders), 32'(prevOrders));
      applyStimulus(1);
      checkOutput($sformatf("tick%0d", k + 1), vecs[k].orders, vecs[k].times, vecs[k].points, 1'b0, 1'b0);
      prevOrders = vecs[k].orders;
      prevTimes  = vecs[k].times;
    end

    // Back-to-back serves: first takes the only order, second finds nothing.
    serve_valid = 1'b1;
    applyStimulus(1);
    checkOutput("serveA", 4'b0000, packT(0, 0, 0, 0), 10'd22, 1'b1, 1'b0);
    applyStimulus(1);
    checkOutput("serveEmpty", 4'b0000, packT(0, 0, 0, 0), 10'd22, 1'b0, 1'b1);
    serve_valid = 1'b0;
    applyStimulus(1);
    checkOutput("serveIdle", 4'b0000, packT(0, 0, 0, 0), 10'd22, 1'b0, 1'b0);
    applyStimulus(7);
    checkOutput("tick11", 4'b0001, packT(3, 0, 0, 0), 10'd22, 1'b0, 1'b0);
    applyStimulus(20);
    checkOutput("tick13", 4'b0011, packT(1, 3, 0, 0), 10'd22, 1'b0, 1'b0);
    applyStimulus(10);
    checkOutput("tick14Penalty", 4'b0010, packT(0, 2, 0, 0), 10'd12, 1'b0, 1'b0);
    applyStimulus(10);
    checkOutput("tick15", 4'b0011, packT(3, 1, 0, 0), 10'd12, 1'b0, 1'b0);

    // Priority: slot 1 holds less time than slot 0, so it is served.
    serve_valid = 1'b1;
    applyStimulus(1);
    serve_valid = 1'b0;
    checkOutput("servePriority", 4'b0001, packT(3, 0, 0, 0), 10'd33, 1'b1, 1'b0);
    applyStimulus(9);
    checkOutput("tick16", 4'b0001, packT(2, 0, 0, 0), 10'd33, 1'b0, 1'b0);

    // Serve on a spawn tick: the slot freed by the serve is not refilled.
    applyStimulus(9);
    checkOutput("preTick17", 4'b0001, packT(2, 0, 0, 0), 10'd33, 1'b0, 1'b0);
    serve_valid = 1'b1;
    applyStimulus(1);
    serve_valid = 1'b0;
    checkOutput("serveOnSpawn", 4'b0010, packT(0, 3, 0, 0), 10'd55, 1'b1, 1'b0);
    applyStimulus(20);
    checkOutput("tick19", 4'b0011, packT(3, 1, 0, 0), 10'd55, 1'b0, 1'b0);

    // Serve on the tick that would expire the target: award only, no penalty.
    applyStimulus(9);
    serve_valid = 1'b1;
    applyStimulus(1);
    serve_valid = 1'b0;
    checkOutput("serveOnExpiry", 4'b0001, packT(2, 0, 0, 0), 10'd76, 1'b1, 1'b0);
    applyStimulus(10);
    checkOutput("tick21", 4'b0011, packT(1, 3, 0, 0), 10'd76, 1'b0, 1'b0);

    // Pause at tick phase 4 for 50 cycles with a rejected serve in the middle.
    applyStimulus(4);
    game_state = 3'd3;
    applyStimulus(25);
    serve_valid = 1'b1;
    applyStimulus(1);
    serve_valid = 1'b0;
    checkOutput("pauseServe", 4'b0011, packT(1, 3, 0, 0), 10'd76, 1'b0, 1'b1);
    applyStimulus(24);
    checkOutput("pauseHold", 4'b0011, packT(1, 3, 0, 0), 10'd76, 1'b0, 1'b0);
    game_state = 3'd2;
    applyStimulus(5);
    checkOutput("resumeEarly", 4'b0011, packT(1, 3, 0, 0), 10'd76, 1'b0, 1'b0);
    applyStimulus(1);
    checkOutput("resumeTick", 4'b0010, packT(0, 2, 0, 0), 10'd66, 1'b0, 1'b0);

    serve_valid = 1'b1;
    applyStimulus(1);
    serve_valid = 1'b0;
    checkOutput("serveB", 4'b0000, packT(0, 0, 0, 0), 10'd88, 1'b1, 1'b0);

    // Serve each fresh order until the score saturates.
    expPoints = 88;
    for (int it = 0; it < 42; it++) begin
      waitForOrder($sformatf("satWait%0d", it));
      checkVal($sformatf("satSpawn%0d.times", it), 32'(order_times), 32'(packT(3, 0, 0, 0)));
      serve_valid = 1'b1;
      applyStimulus(1);
      serve_valid = 1'b0;
      expPoints = (expPoints + 23 > 1023) ? 1023 : expPoints + 23;
      checkVal($sformatf("satServe%0d.points", it), 32'(point_total), 32'(expPoints));
      checkVal($sformatf("satServe%0d.ack", it), 32'(serve_ack), 32'd1);
    end
    checkVal("saturated", 32'(point_total), 32'd1023);

    // Reset during PLAY with a serve in flight drops the response.
    waitForOrder("resetWait");
    serve_valid = 1'b1;
    reset = 1'b1;
    applyStimulus(1);
    checkOutput("midReset", 4'b0000, 20'd0, 10'd0, 1'b0, 1'b0);
    reset = 1'b0;
    serve_valid = 1'b0;
    applyStimulus(1);
    checkOutput("afterReset", 4'b0000, 20'd0, 10'd0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no completion want finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
